// File: rtl/mctp_axil_arbiter_if.sv
// AXI-lite bundle for the MCTP arbiter: N lanes of packed aw/w/b/ar/r signals.
// The arbiter uses it as a slave toward the bridges and as a master toward PMCI.
interface mctp_axil_arbiter_if #(
   parameter int N      = 1,
   parameter int ADDR_W = 19,
   parameter int DATA_W = 64
);
   logic [N-1:0]            awvalid;
   logic [N*ADDR_W-1:0]     awaddr;
   logic [N-1:0]            awready;
   logic [N-1:0]            wvalid;
   logic [N*DATA_W-1:0]     wdata;
   logic [N*DATA_W/8-1:0]   wstrb;
   logic [N-1:0]            wready;
   logic [N-1:0]            bvalid;
   logic [N*2-1:0]          bresp;
   logic [N-1:0]            bready;
   logic [N-1:0]            arvalid;
   logic [N*ADDR_W-1:0]     araddr;
   logic [N-1:0]            arready;
   logic [N-1:0]            rvalid;
   logic [N*DATA_W-1:0]     rdata;
   logic [N*2-1:0]          rresp;
   logic [N-1:0]            rready;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/mctp_axil_arbiter.sv
// Round-robin AXI-lite arbiter sharing the PMCI port between MCTP VDM bridges,
// with per-requester grant lock. Define MCTP_ARB_TIMEOUT_EN for the response timeout.
module mctp_axil_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_W      = 19,
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_lock,
   mctp_axil_arbiter_if.slave         req,
   mctp_axil_arbiter_if.master        m,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int SW = DATA_W / 8;

   if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYC < 2) begin : g_bad_param
      $error("mctp_axil_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYC at least 2");
   end

`ifdef MCTP_ARB_TIMEOUT_EN
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WRESP, S_RRESP, S_LOCKED, S_DRAIN} state_e;
   localparam int            TW      = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] CNT_MAX = TW'(TIMEOUT_CYC - 1);
   logic [TW-1:0] cnt_q, cnt_d;
   logic          tmo_q, tmo_d;
`else
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WRESP, S_RRESP, S_LOCKED} state_e;
`endif

   state_e          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
   logic            is_write_q, is_write_d;
   logic            aw_done_q, aw_done_d;
   logic            w_done_q, w_done_d;

   logic [NUM_REQ-1:0] wr_pend, requesting;
   logic               pick_found;
   logic [GW-1:0]      pick_idx;
   logic [GW-1:0]      rr_next;
   logic               aw_fire, w_fire, xact_done;

   assign wr_pend    = req.awvalid & req.wvalid;
   assign requesting = wr_pend | req.arvalid;
   assign rr_next    = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
   assign grant_id   = grant_q;

   // Walk downward so the last hit is the first requester at or after rr_ptr.
   always_comb begin
      int idx;
      pick_found = 1'b0;
      pick_idx   = rr_ptr_q;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (requesting[idx]) begin
            pick_found = 1'b1;
            pick_idx   = idx[GW-1:0];
         end
      end
   end

   always_comb begin
      // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      is_write_d = is_write_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      aw_fire    = 1'b0;
      w_fire     = 1'b0;
      xact_done  = 1'b0;
`ifdef MCTP_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
`endif
      m.awvalid   = '0;
      m.awaddr    = '0;
      m.wvalid    = '0;
      m.wdata     = '0;
      m.wstrb     = '0;
      m.bready    = '0;
      m.arvalid   = '0;
      m.araddr    = '0;
      m.rready    = '0;
      req.awready = '0;
      req.wready  = '0;
      req.bvalid  = '0;
      req.bresp   = '0;
      req.arready = '0;
      req.rvalid  = '0;
      req.rdata   = '0;
      req.rresp   = '0;

      unique case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_d    = pick_idx;
               is_write_d = wr_pend[pick_idx];
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
               state_d    = S_ADDR;
            end
         end

         S_ADDR: begin
            if (is_write_q) begin
               m.awvalid             = req.awvalid[grant_q] & ~aw_done_q;
               m.awaddr              = req.awaddr[grant_q*ADDR_W +: ADDR_W];
               m.wvalid              = req.wvalid[grant_q] & ~w_done_q;
               m.wdata               = req.wdata[grant_q*DATA_W +: DATA_W];
               m.wstrb               = req.wstrb[grant_q*SW +: SW];
               req.awready[grant_q]  = m.awready & ~aw_done_q;
               req.wready[grant_q]   = m.wready & ~w_done_q;
               aw_fire   = req.awvalid[grant_q] & m.awready & ~aw_done_q;
               w_fire    = req.wvalid[grant_q] & m.wready & ~w_done_q;
               aw_done_d = aw_done_q | aw_fire;
               w_done_d  = w_done_q | w_fire;
               if (aw_done_d && w_done_d) state_d = S_WRESP;
            end else begin
               m.arvalid            = req.arvalid[grant_q];
               m.araddr             = req.araddr[grant_q*ADDR_W +: ADDR_W];
               req.arready[grant_q] = m.arready;
               if (req.arvalid[grant_q] && m.arready) state_d = S_RRESP;
            end
`ifdef MCTP_ARB_TIMEOUT_EN
            cnt_d = '0;
            tmo_d = 1'b0;
`endif
         end

         S_WRESP: begin
`ifdef MCTP_ARB_TIMEOUT_EN
            // Once timed out, the requester gets SLVERR and the master response waits for DRAIN.
            if (tmo_q || (cnt_q == CNT_MAX && !m.bvalid)) begin
               tmo_d                    = 1'b1;
               req.bvalid[grant_q]      = 1'b1;
               req.bresp[grant_q*2 +: 2] = 2'b10;
               if (req.bready[grant_q]) state_d = S_DRAIN;
            end else begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
`endif
               req.bvalid[grant_q]       = m.bvalid;
               req.bresp[grant_q*2 +: 2] = m.bresp;
               m.bready                  = req.bready[grant_q];
               xact_done                 = m.bvalid & req.bready[grant_q];
`ifdef MCTP_ARB_TIMEOUT_EN
            end
`endif
         end

         S_RRESP: begin
`ifdef MCTP_ARB_TIMEOUT_EN
            if (tmo_q || (cnt_q == CNT_MAX && !m.rvalid)) begin
               tmo_d                     = 1'b1;
               req.rvalid[grant_q]       = 1'b1;
               req.rresp[grant_q*2 +: 2] = 2'b10;
               if (req.rready[grant_q]) state_d = S_DRAIN;
            end else begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
`endif
               req.rvalid[grant_q]                = m.rvalid;
               req.rdata[grant_q*DATA_W +: DATA_W] = m.rdata;
               req.rresp[grant_q*2 +: 2]          = m.rresp;
               m.rready                           = req.rready[grant_q];
               xact_done                          = m.rvalid & req.rready[grant_q];
`ifdef MCTP_ARB_TIMEOUT_EN
            end
`endif
         end

         S_LOCKED: begin
            if (requesting[grant_q]) begin
               is_write_d = wr_pend[grant_q];
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
               state_d    = S_ADDR;
            end else if (!req_lock[grant_q]) begin
               rr_ptr_d = rr_next;
               state_d  = S_IDLE;
            end
         end

`ifdef MCTP_ARB_TIMEOUT_EN
         S_DRAIN: begin
            if (is_write_q) begin
               m.bready  = 1'b1;
               xact_done = m.bvalid;
            end else begin
               m.rready  = 1'b1;
               xact_done = m.rvalid;
            end
         end
`endif

         default: state_d = S_IDLE;
      endcase

      if (xact_done) begin
         if (req_lock[grant_q]) begin
            state_d = S_LOCKED;
         end else begin
            rr_ptr_d = rr_next;
            state_d  = S_IDLE;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         is_write_q <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
`ifdef MCTP_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         tmo_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         is_write_q <= is_write_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
`ifdef MCTP_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
`endif
      end
   end
endmodule

// File: tb/tb_mctp_axil_arbiter.sv
// Directed bench for mctp_axil_arbiter: reset, single write, round-robin, lock,
// read routing, split aw/w, mid-transaction reset, and the timeout when enabled.
module tb_mctp_axil_arbiter;
   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 19;
   localparam int DATA_W  = 64;
`ifdef MCTP_ARB_TIMEOUT_EN
   localparam int TMO_CYC = 16;
`else
   localparam int TMO_CYC = 1024;
`endif

   logic               clk;
   logic               rst;
   logic [NUM_REQ-1:0] req_lock;
   logic [0:0]         grant_id;

   int n_cmp  = 0;
   int n_fail = 0;

   mctp_axil_arbiter_if #(.N(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) rq ();
   mctp_axil_arbiter_if #(.N(1),       .ADDR_W(ADDR_W), .DATA_W(DATA_W)) mi ();

   mctp_axil_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO_CYC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_lock (req_lock),
      .req      (rq),
      .m        (mi),
      .grant_id (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, required finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      req_lock   = '0;
      rq.awvalid = '0; rq.awaddr = '0; rq.wvalid = '0; rq.wdata = '0; rq.wstrb = '0;
      rq.bready  = '0; rq.arvalid = '0; rq.araddr = '0; rq.rready = '0;
      mi.awready = '0; mi.wready = '0; mi.bvalid = '0; mi.bresp = '0;
      mi.arready = '0; mi.rvalid = '0; mi.rdata = '0; mi.rresp = '0;
   endtask

   task automatic set_wr(input int r, input logic v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
      rq.awvalid[r]                 = v;
      rq.wvalid[r]                  = v;
      rq.awaddr[r*ADDR_W +: ADDR_W] = a;
      rq.wdata[r*DATA_W +: DATA_W]  = d;
      rq.wstrb[r*8 +: 8]            = 8'hff;
   endtask

   // Leaves rst asserted at a negedge after at least one reset posedge.
   task automatic reset_on();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
   endtask

   logic [ADDR_W-1:0] lock_addr [4];
   logic [ADDR_W-1:0] rec_addr  [8];
   logic [0:0]        rec_gnt   [8];
   int                rec_cyc   [8];
   int                nrec, n0, nb0, hold, drop_cyc, tmo_k;

   initial begin
      lock_addr[0] = 19'h22000; lock_addr[1] = 19'h22008;
      lock_addr[2] = 19'h22008; lock_addr[3] = 19'h22000;
      rst = 1'b1;
      clear_inputs();

      // ---------------- reset state ----------------
      reset_on();
      #1;
      check("rst_grant_id", grant_id, 0);
      check("rst_m_awvalid", mi.awvalid, 0);
      check("rst_m_wvalid", mi.wvalid, 0);
      check("rst_m_arvalid", mi.arvalid, 0);
      check("rst_m_bready", mi.bready, 0);
      check("rst_m_rready", mi.rready, 0);
      check("rst_m_awaddr", mi.awaddr, 0);
      check("rst_m_wdata", mi.wdata, 0);
      check("rst_req_awready", rq.awready, 0);
      check("rst_req_rdata", rq.rdata, 0);
      check("rst_rr_ptr", dut.rr_ptr_q, 0);

      // ---------------- single write by req0 ----------------
      set_wr(0, 1'b1, 19'h22000, 64'h1);
      rq.bready = 2'b11; mi.awready = 1'b1; mi.wready = 1'b1;
      rst = 1'b0;
      check("wr_idle_no_awvalid", mi.awvalid, 0);
      @(negedge clk); #1;
      check("wr_m_awvalid", mi.awvalid, 1);
      check("wr_m_awaddr", mi.awaddr, 19'h22000);
      check("wr_m_wvalid", mi.wvalid, 1);
      check("wr_m_wdata", mi.wdata, 64'h1);
      check("wr_m_wstrb", mi.wstrb, 8'hff);
      check("wr_req_awready", rq.awready, 2'b01);
      check("wr_req_wready", rq.wready, 2'b01);
      check("wr_grant_id", grant_id, 0);
      @(negedge clk);
      set_wr(0, 1'b0, 19'h0, 64'h0);
      mi.bvalid = 1'b1; mi.bresp = 2'b00;
      #1;
      check("wr_req_bvalid", rq.bvalid, 2'b01);
      check("wr_req_bresp", rq.bresp, 4'b0000);
      check("wr_m_bready", mi.bready, 1);
      check("wr_resp_no_awvalid", mi.awvalid, 0);
      @(negedge clk);
      mi.bvalid = 1'b0;
      #1;
      check("wr_done_bvalid", rq.bvalid, 0);
      check("wr_done_rr_ptr", dut.rr_ptr_q, 1);
      check("wr_done_grant_id", grant_id, 0);

      // ---------------- round-robin, both requesting from reset exit ----------------
      reset_on();
      set_wr(0, 1'b1, 19'h00100, 64'h10);
      set_wr(1, 1'b1, 19'h00200, 64'h20);
      rq.bready = 2'b11; mi.awready = 1'b1; mi.wready = 1'b1; mi.bvalid = 1'b1;
      rst = 1'b0;
      nrec = 0;
      for (int cyc = 0; cyc < 30 && nrec < 4; cyc++) begin
         @(negedge clk); #1;
         if (mi.awvalid[0]) begin
            rec_gnt[nrec]  = grant_id;
            rec_addr[nrec] = mi.awaddr;
            nrec++;
         end
      end
      check("rr_count", nrec, 4);
      check("rr_g0", rec_gnt[0], 0);
      check("rr_g1", rec_gnt[1], 1);
      check("rr_g2", rec_gnt[2], 0);
      check("rr_g3", rec_gnt[3], 1);
      check("rr_a0", rec_addr[0], 19'h00100);
      check("rr_a1", rec_addr[1], 19'h00200);
      check("rr_a2", rec_addr[2], 19'h00100);
      check("rr_a3", rec_addr[3], 19'h00200);

      // ---------------- lock: req0 SOP/data/data/EOP, req1 waiting ----------------
      reset_on();
      req_lock = 2'b01;
      set_wr(0, 1'b1, lock_addr[0], 64'h0);
      set_wr(1, 1'b1, 19'h00300, 64'h3);
      rq.bready = 2'b11; mi.awready = 1'b1; mi.wready = 1'b1; mi.bvalid = 1'b1;
      rst = 1'b0;
      nrec = 0; n0 = 0; nb0 = 0; hold = 0; drop_cyc = -100;
      for (int cyc = 0; cyc < 60 && nrec < 5; cyc++) begin
         @(negedge clk);
         set_wr(0, n0 < 4, lock_addr[(n0 < 4) ? n0 : 3], 64'(n0));
         if (nb0 == 4) begin
            if (hold == 2) begin
               req_lock[0] = 1'b0;
               drop_cyc    = cyc;
            end
            hold++;
         end
         #1;
         if (mi.awvalid[0]) begin
            rec_gnt[nrec]  = grant_id;
            rec_addr[nrec] = mi.awaddr;
            rec_cyc[nrec]  = cyc;
            nrec++;
            if (grant_id == 1'b0) n0++;
         end
         if (rq.bvalid[0] && rq.bready[0]) nb0++;
      end
      check("lock_count", nrec, 5);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("lock_g%0d", i), rec_gnt[i], 0);
         check($sformatf("lock_a%0d", i), rec_addr[i], lock_addr[i]);
      end
      check("lock_req1_grant", rec_gnt[4], 1);
      check("lock_req1_addr", rec_addr[4], 19'h00300);
      check("lock_req1_latency", rec_cyc[4] - drop_cyc, 2);

      // ---------------- read by req1 ----------------
      reset_on();
      rq.arvalid[1] = 1'b1;
      rq.araddr[ADDR_W +: ADDR_W] = 19'h22010;
      rq.rready = 2'b11; mi.arready = 1'b1;
      rst = 1'b0;
      @(negedge clk); #1;
      check("rd_m_arvalid", mi.arvalid, 1);
      check("rd_m_araddr", mi.araddr, 19'h22010);
      check("rd_grant_id", grant_id, 1);
      check("rd_req_arready", rq.arready, 2'b10);
      @(negedge clk);
      rq.arvalid[1] = 1'b0;
      mi.rvalid = 1'b1; mi.rdata = 64'hDEADBEEF_00000001; mi.rresp = 2'b00;
      #1;
      check("rd_req_rvalid", rq.rvalid, 2'b10);
      check("rd_req1_rdata", rq.rdata[127:64], 64'hDEADBEEF_00000001);
      check("rd_req0_rdata", rq.rdata[63:0], 64'h0);
      check("rd_req_rresp", rq.rresp, 4'b0000);
      check("rd_m_rready", mi.rready, 1);
      @(negedge clk);
      mi.rvalid = 1'b0;
      #1;
      check("rd_done_rvalid", rq.rvalid, 0);
      check("rd_done_rr_ptr", dut.rr_ptr_q, 0);

      // ---------------- split aw/w handshakes ----------------
      reset_on();
      set_wr(0, 1'b1, 19'h22018, 64'h55);
      rq.bready = 2'b01;
      rst = 1'b0;
      @(negedge clk);
      mi.awready = 1'b1;
      #1;
      check("split_awready", rq.awready, 2'b01);
      check("split_wready_low", rq.wready, 2'b00);
      check("split_m_awvalid", mi.awvalid, 1);
      @(negedge clk);
      rq.awvalid[0] = 1'b0; mi.awready = 1'b0;
      #1;
      check("split_aw_dropped", mi.awvalid, 0);
      check("split_w_pending", mi.wvalid, 1);
      check("split_no_bready", mi.bready, 0);
      @(negedge clk);
      mi.bvalid = 1'b1;
      #1;
      check("split_early_bvalid_blocked", rq.bvalid, 2'b00);
      @(negedge clk);
      mi.wready = 1'b1;
      #1;
      check("split_wready", rq.wready, 2'b01);
      check("split_no_second_aw", mi.awvalid, 0);
      @(negedge clk);
      rq.wvalid[0] = 1'b0; mi.wready = 1'b0;
      #1;
      check("split_bvalid", rq.bvalid, 2'b01);
      check("split_m_bready", mi.bready, 1);
      @(negedge clk);
      mi.bvalid = 1'b0;

      // ---------------- reset mid-transaction ----------------
      reset_on();
      set_wr(0, 1'b1, 19'h22020, 64'h7);
      rq.bready = 2'b11;
      rst = 1'b0;
      @(negedge clk); #1;
      check("mrst_m_awvalid", mi.awvalid, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      mi.bvalid = 1'b1;
      #1;
      check("mrst_awvalid_drop", mi.awvalid, 0);
      check("mrst_wvalid_drop", mi.wvalid, 0);
      check("mrst_bready", mi.bready, 0);
      check("mrst_req_bvalid", rq.bvalid, 0);

`ifdef MCTP_ARB_TIMEOUT_EN
      // ---------------- response timeout and drain ----------------
      reset_on();
      set_wr(0, 1'b1, 19'h22000, 64'h1);
      rq.bready = 2'b11; mi.awready = 1'b1; mi.wready = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      set_wr(0, 1'b0, 19'h0, 64'h0);
      tmo_k = -1;
      for (int k = 1; k <= 40; k++) begin
         if (k > 1) @(negedge clk);
         #1;
         if (rq.bvalid[0]) begin
            tmo_k = k;
            break;
         end
      end
      check("tmo_cycle", tmo_k, 16);
      check("tmo_bresp", rq.bresp[1:0], 2'b10);
      for (int k = 17; k < 30; k++) begin
         @(negedge clk);
      end
      @(negedge clk);
      mi.bvalid = 1'b1;
      #1;
      check("tmo_drain_bready", mi.bready, 1);
      check("tmo_late_absorbed", rq.bvalid, 0);
      @(negedge clk);
      mi.bvalid = 1'b0;
      set_wr(1, 1'b1, 19'h22040, 64'h9);
      @(negedge clk); #1;
      check("tmo_next_grant", grant_id, 1);
      check("tmo_next_awaddr", mi.awaddr, 19'h22040);
      @(negedge clk);
      set_wr(1, 1'b0, 19'h0, 64'h0);
      mi.bvalid = 1'b1; mi.bresp = 2'b00;
      #1;
      check("tmo_next_bvalid", rq.bvalid, 2'b10);
      check("tmo_next_bresp", rq.bresp, 4'b0000);
      @(negedge clk);
      mi.bvalid = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/mctp_axil_arbiter.md
Name: mctp_axil_arbiter

Overview:
- Shares the single PMCI AXI-lite master port between NUM_REQ MCTP requesters: requester 0 is the RX VDM bridge, requester 1 is the TX VDM bridge.
- Grants round-robin, one transaction outstanding at a time.
- A requester asserting req_lock keeps the grant across several transactions, so that a complete SOP..data..EOP mailbox sequence is never interleaved with another requester's.
- Sits between the bridges and the PMCI CSR AXI-lite fabric.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_W, 19, AXI-lite address width
DATA_W, 64, AXI-lite data width; strobe width is DATA_W/8
TIMEOUT_CYC, 1024, response timeout in clk cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_lock  in  NUM_REQ  hold grant after the current transaction
req_awvalid  in  NUM_REQ  write address valid, per requester
req_awaddr  in  NUM_REQ*ADDR_W  write addresses, packed by requester
req_awready  out  NUM_REQ  write address ready
req_wvalid  in  NUM_REQ  write data valid
req_wdata  in  NUM_REQ*DATA_W  write data
req_wstrb  in  NUM_REQ*DATA_W/8  write strobes
req_wready  out  NUM_REQ  write data ready
req_bvalid  out  NUM_REQ  write response valid
req_bresp  out  NUM_REQ*2  write response
req_bready  in  NUM_REQ  write response ready
req_arvalid  in  NUM_REQ  read address valid
req_araddr  in  NUM_REQ*ADDR_W  read addresses
req_arready  out  NUM_REQ  read address ready
req_rvalid  out  NUM_REQ  read data valid
req_rdata  out  NUM_REQ*DATA_W  read data
req_rresp  out  NUM_REQ*2  read response
req_rready  in  NUM_REQ  read data ready
m_awvalid/m_awaddr/m_wvalid/m_wdata/m_wstrb/m_bready/m_arvalid/m_araddr/m_rready  out  1/ADDR_W/1/DATA_W/DATA_W/8/1/1/ADDR_W/1  master request side
m_awready/m_wready/m_bvalid/m_bresp/m_arready/m_rvalid/m_rdata/m_rresp  in  1/1/1/2/1/1/DATA_W/2  master response side
grant_id  out  $clog2(NUM_REQ)  currently granted requester (debug)

Behaviour:
- Reset: all valid/ready outputs are 0, all data outputs are 0, grant_id=0, rr_ptr=0, state=IDLE.

FSM states:
- IDLE:
  - A requester is "requesting" if awvalid&wvalid, or arvalid, is asserted.
  - Pick the first requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register grant_id and go to ADDR next cycle. Arbitration latency is 1 cycle.
- ADDR:
  - Write has priority over read for the same requester when both are pending; the choice is latched on entry.
  - Write: drive m_aw*/m_w* combinationally from the granted requester.
    - Each channel is passed through independently (aw and w may complete in different cycles).
    - The granted requester's awready/wready mirror m_awready/m_wready.
    - Once both handshakes are done, go to WRESP.
  - Read: pass through ar; after the handshake, go to RRESP.
  - Non-granted requesters see all readies and valids at 0.
- WRESP / RRESP:
  - Route m_bvalid/m_bresp (or m_rvalid/m_rdata/m_rresp) to the granted requester.
  - m_bready/m_rready = that requester's ready.
  - On the response handshake:
    - if req_lock[grant_id]=1, go to LOCKED;
    - otherwise set rr_ptr=grant_id+1 (mod NUM_REQ) and go to IDLE.
- LOCKED:
  - Only grant_id may start a transaction; go to ADDR as soon as it is requesting. Others wait.
  - If req_lock[grant_id] drops while no request is pending, advance rr_ptr and go to IDLE.
- Grant and lock rules:
  - Lock is sampled only at response completion or in LOCKED.
  - Asserting lock in IDLE does not itself grant.
  - grant_id never changes outside IDLE.
- Pass-through data paths: zero added latency on aw/w/ar/b/r. Only the grant decision is registered.
- Simultaneous requests at reset exit: index 0 wins.
- Reset mid-transaction: returns to IDLE immediately and all master valids drop. A response arriving afterwards is ignored (m_bready/m_rready=0).

Optional Feature:
- Macro: MCTP_ARB_TIMEOUT_EN
- Defined:
  - A counter starts when the ADDR-phase handshakes complete.
  - If TIMEOUT_CYC cycles elapse in WRESP/RRESP without m_bvalid/m_rvalid:
    - return SLVERR (2'b10) to the requester; rdata=0 for reads;
    - enter DRAIN, holding m_bready/m_rready=1 until the late master response arrives, which is discarded;
    - then follow the normal lock/rr_ptr rules.
  - Lock is honoured after a timeout.
- Not defined: no counter and no DRAIN state; the response wait is unbounded.

Test Plan:
- Single write: req0 writes 0x22000 data 0x1 -> one m_aw/m_w with identical addr/data; req0 bvalid with bresp 0; grant_id=0; rr_ptr=1.
- Round-robin: req0 and req1 both request continuously (no lock) -> master sees alternating grants 0,1,0,1 over 4 transactions.
- Lock: req0 holds lock across 4 writes (SOP 0x22000, data 0x22008 x2, EOP 0x22000) while req1 requests -> req1's transaction starts only after the 4th bresp and lock deassert.
- Read path: req1 reads 0x22010, master returns 0xDEADBEEF_00000001 -> req1 rdata matches, rresp 0; req0 sees no rvalid.
- Split aw/w: m_awready rises 3 cycles before m_wready -> a single transaction; awvalid drops after its handshake; WRESP is entered only after the w handshake.
- With MCTP_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, no bvalid -> req bresp=2'b10 at cycle 16; a late m_bvalid at cycle 30 is absorbed; the next grant then proceeds normally.
